// File: rtl/datapath_ctrl_pkg.sv
// Shared types and constants for the simple-RISC datapath controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package datapath_ctrl_pkg;

   localparam int NSEL_W = 3;
   localparam int VSEL_W = 2;

   typedef enum logic [2:0] {
      WAIT      = 3'd0,
      DECODE    = 3'd1,
      GET_A     = 3'd2,
      GET_B     = 3'd3,
      COMPUTE   = 3'd4,
      WRITE_REG = 3'd5,
      WRITE_IMM = 3'd6,
      HALT      = 3'd7
   } state_t;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_MVN = 2'b11;

   // MOV uses its op field to pick immediate (10) vs register (00) form
   localparam logic [1:0] MOV_REG = 2'b00;
   localparam logic [1:0] MOV_IMM = 2'b10;

   localparam logic [NSEL_W-1:0] NSEL_NONE = 3'b000;
   localparam logic [NSEL_W-1:0] NSEL_RN   = 3'b001;
   localparam logic [NSEL_W-1:0] NSEL_RD   = 3'b010;
   localparam logic [NSEL_W-1:0] NSEL_RM   = 3'b100;

   localparam logic [VSEL_W-1:0] VSEL_C     = 2'b00;
   localparam logic [VSEL_W-1:0] VSEL_PC    = 2'b01;
   localparam logic [VSEL_W-1:0] VSEL_IMM   = 2'b10;
   localparam logic [VSEL_W-1:0] VSEL_MDATA = 2'b11;

   // CMP is the only ALU instruction that updates status instead of writing back
   function automatic logic is_cmp(input logic [2:0] opc, input logic [1:0] op);
      return (opc == OPC_ALU) && (op == ALU_SUB);
   endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// Decoder-side inputs and datapath control strobes of the controller.
// Latency: n/a (wiring only).
// Backpressure: s is only honoured while w=1; master is the controller.
interface datapath_ctrl_if;
   import datapath_ctrl_pkg::*;

   logic              s;
   logic [2:0]        opcode;
   logic [1:0]        op;
   logic              w;
   logic [NSEL_W-1:0] nsel;
   logic [VSEL_W-1:0] vsel;
   logic              loada;
   logic              loadb;
   logic              loadc;
   logic              loads;
   logic              asel;
   logic              bsel;
   logic              write;
   logic [1:0]        alu_op;
   logic              err;

   modport master (
      input  s, opcode, op,
      output w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, alu_op, err
   );

   modport slave (
      output s, opcode, op,
      input  w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, alu_op, err
   );
endinterface

// File: rtl/datapath_ctrl_outdec.sv
// Moore output decoder: state plus latched instruction fields to datapath strobes.
// Latency: purely combinational, zero cycles.
// Backpressure: none; w_o=1 only in WAIT signals readiness. HALT decode under DATAPATH_CTRL_ILLEGAL_TRAP_EN.
module datapath_ctrl_outdec
   import datapath_ctrl_pkg::*;
(
   input  state_t            state_i,
   input  logic [2:0]        opc_i,
   input  logic [1:0]        op_i,
   output logic              w_o,
   output logic [NSEL_W-1:0] nsel_o,
   output logic [VSEL_W-1:0] vsel_o,
   output logic              loada_o,
   output logic              loadb_o,
   output logic              loadc_o,
   output logic              loads_o,
   output logic              asel_o,
   output logic              bsel_o,
   output logic              write_o,
   output logic [1:0]        alu_op_o,
   output logic              err_o
);

   // Everything defaults low; each state raises only its own strobes
   always_comb begin
      w_o      = 1'b0;
      nsel_o   = NSEL_NONE;
      vsel_o   = VSEL_C;
      loada_o  = 1'b0;
      loadb_o  = 1'b0;
      loadc_o  = 1'b0;
      loads_o  = 1'b0;
      asel_o   = 1'b0;
      bsel_o   = 1'b0;
      write_o  = 1'b0;
      alu_op_o = ALU_ADD;
      err_o    = 1'b0;
      case (state_i)
         WAIT: w_o = 1'b1;
         GET_A: begin
            nsel_o  = NSEL_RN;
            loada_o = 1'b1;
         end
         GET_B: begin
            nsel_o  = NSEL_RM;
            loadb_o = 1'b1;
         end
         COMPUTE: begin
            if (opc_i == OPC_MOV) begin
               // 0 + shifted Rm: the ALU acts as a pass-through for MOV reg
               alu_op_o = ALU_ADD;
               asel_o   = 1'b1;
            end else begin
               alu_op_o = op_i;
            end
            if (is_cmp(opc_i, op_i)) loads_o = 1'b1;
            else                     loadc_o = 1'b1;
         end
         WRITE_REG: begin
            nsel_o  = NSEL_RD;
            vsel_o  = VSEL_C;
            write_o = 1'b1;
         end
         WRITE_IMM: begin
            nsel_o  = NSEL_RN;
            vsel_o  = VSEL_IMM;
            write_o = 1'b1;
         end
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
         HALT: err_o = 1'b1;
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle controller: latches one instruction on s and sequences RF read, ALU, status/writeback.
// Latency: s-accept to w=1 is 3 (MOV imm), 5 (MOV reg/MVN/CMP), 6 (ADD/AND) cycles.
// Backpressure: s is ignored while w=0; illegal decode traps in HALT when DATAPATH_CTRL_ILLEGAL_TRAP_EN is defined, else NOP.
module datapath_ctrl
   import datapath_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   datapath_ctrl_if.master bus
);

   state_t     state_q, state_d;
   logic [2:0] opc_q,   opc_d;
   logic [1:0] op_q,    op_d;

   // State and latched instruction fields; reset aborts any instruction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WAIT;
         opc_q   <= 3'b000;
         op_q    <= 2'b00;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         op_q    <= op_d;
      end
   end

   // Next-state logic; decoder inputs are only looked at in WAIT
   always_comb begin
      state_d = state_q;
      opc_d   = opc_q;
      op_d    = op_q;
      case (state_q)
         WAIT: begin
            if (bus.s) begin
               opc_d   = bus.opcode;
               op_d    = bus.op;
               state_d = DECODE;
            end
         end
         DECODE: begin
            case ({opc_q, op_q})
               {OPC_MOV, MOV_IMM}:  state_d = WRITE_IMM;
               {OPC_MOV, MOV_REG}:  state_d = GET_B;
               {OPC_ALU, ALU_MVN}:  state_d = GET_B;
               {OPC_ALU, ALU_ADD},
               {OPC_ALU, ALU_SUB},
               {OPC_ALU, ALU_AND}:  state_d = GET_A;
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
               default:             state_d = HALT;
`else
               default:             state_d = WAIT;
`endif
            endcase
         end
         GET_A:   state_d = GET_B;
         GET_B:   state_d = COMPUTE;
         COMPUTE: state_d = is_cmp(opc_q, op_q) ? WAIT : WRITE_REG;
         WRITE_REG,
         WRITE_IMM: state_d = WAIT;
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
         HALT:    state_d = HALT;
`endif
         default: state_d = WAIT;
      endcase
   end

   datapath_ctrl_outdec u_outdec (
      .state_i  (state_q),
      .opc_i    (opc_q),
      .op_i     (op_q),
      .w_o      (bus.w),
      .nsel_o   (bus.nsel),
      .vsel_o   (bus.vsel),
      .loada_o  (bus.loada),
      .loadb_o  (bus.loadb),
      .loadc_o  (bus.loadc),
      .loads_o  (bus.loads),
      .asel_o   (bus.asel),
      .bsel_o   (bus.bsel),
      .write_o  (bus.write),
      .alu_op_o (bus.alu_op),
      .err_o    (bus.err)
   );

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl: per-cycle output traces checked against hand-built vectors.
// Latency: traces are indexed by cycles after the s-accept edge.
// Backpressure: s is held across an instruction to exercise back-to-back acceptance.
module tb_datapath_ctrl;
   import datapath_ctrl_pkg::*;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   datapath_ctrl_if bus ();

   datapath_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, alu_op, err}
   function automatic logic [15:0] snap();
      return {bus.w, bus.nsel, bus.vsel, bus.loada, bus.loadb, bus.loadc, bus.loads,
              bus.asel, bus.bsel, bus.write, bus.alu_op, bus.err};
   endfunction

   function automatic logic [15:0] e(input logic w, input logic [2:0] ns, input logic [1:0] vs,
                                     input logic la, input logic lb, input logic lc, input logic ls,
                                     input logic as, input logic wr, input logic [1:0] alu,
                                     input logic er);
      return {w, ns, vs, la, lb, lc, ls, as, 1'b0, wr, alu, er};
   endfunction

   // Hand-computed output vectors
   logic [15:0] IDLE, NONE, LDA, LDB, WR_REG, WR_IMM;
   initial begin
      IDLE   = e(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      NONE   = e(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      LDA    = e(0, 3'b001, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 0);
      LDB    = e(0, 3'b100, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 0);
      WR_REG = e(0, 3'b010, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 0);
      WR_IMM = e(0, 3'b001, 2'b10, 0, 0, 0, 0, 0, 1, 2'b00, 0);
   end

   // Present one instruction for a single cycle; returns just after the accept edge
   task automatic issue(input logic [2:0] opc, input logic [1:0] o);
      @(negedge clk);
      bus.s      = 1'b1;
      bus.opcode = opc;
      bus.op     = o;
      @(posedge clk);
      #1;
      bus.s      = 1'b0;
      bus.opcode = 3'b000;
      bus.op     = 2'b00;
   endtask

   task automatic test_reset();
      logic [15:0] got;
      rst_n = 1'b0;
      @(negedge clk);
      got = snap();
      tests_run++;
      if (got !== IDLE) begin
         tests_failed++;
         $display("FAIL reset_state: got %h expected %h", got, IDLE);
      end
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      got = snap();
      tests_run++;
      if (got !== IDLE) begin
         tests_failed++;
         $display("FAIL reset_idle_s0: got %h expected %h", got, IDLE);
      end
   endtask

   task automatic test_idle_ignores_fields();
      logic [15:0] got;
      bus.opcode = OPC_ALU;
      bus.op     = ALU_ADD;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         got = snap();
         tests_run++;
         if (got !== IDLE) begin
            tests_failed++;
            $display("FAIL idle_no_s cycle %0d: got %h expected %h", k, got, IDLE);
         end
      end
      bus.opcode = 3'b000;
      bus.op     = 2'b00;
   endtask

   task automatic test_mov_imm();
      logic [15:0] ex [1:3];
      logic [15:0] got;
      ex[1] = NONE; ex[2] = WR_IMM; ex[3] = IDLE;
      issue(OPC_MOV, 2'b10);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         got = snap();
         tests_run++;
         if (got !== ex[k]) begin
            tests_failed++;
            $display("FAIL mov_imm cycle %0d: got %h expected %h", k, got, ex[k]);
         end
      end
   endtask

   task automatic test_alu3(input string name, input logic [1:0] o);
      logic [15:0] ex [1:6];
      logic [15:0] got;
      ex[1] = NONE; ex[2] = LDA; ex[3] = LDB;
      ex[4] = e(0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0, o, 0);
      ex[5] = WR_REG; ex[6] = IDLE;
      issue(OPC_ALU, o);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         got = snap();
         tests_run++;
         if (got !== ex[k]) begin
            tests_failed++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, k, got, ex[k]);
         end
      end
   endtask

   task automatic test_cmp();
      logic [15:0] ex [1:5];
      logic [15:0] got;
      ex[1] = NONE; ex[2] = LDA; ex[3] = LDB;
      ex[4] = e(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0, 2'b01, 0);
      ex[5] = IDLE;
      issue(OPC_ALU, 2'b01);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         got = snap();
         tests_run++;
         if (got !== ex[k]) begin
            tests_failed++;
            $display("FAIL cmp cycle %0d: got %h expected %h", k, got, ex[k]);
         end
      end
   endtask

   task automatic test_mov_reg_mvn(input string name, input logic [2:0] opc, input logic [1:0] o,
                                   input logic as, input logic [1:0] alu);
      logic [15:0] ex [1:5];
      logic [15:0] got;
      ex[1] = NONE; ex[2] = LDB;
      ex[3] = e(0, 3'b000, 2'b00, 0, 0, 1, 0, as, 0, alu, 0);
      ex[4] = WR_REG; ex[5] = IDLE;
      issue(opc, o);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         got = snap();
         tests_run++;
         if (got !== ex[k]) begin
            tests_failed++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, k, got, ex[k]);
         end
      end
   endtask

   // MOV imm immediately followed by ADD with s held high throughout
   task automatic test_back_to_back();
      logic [15:0] ex [1:9];
      logic [15:0] got;
      ex[1] = NONE; ex[2] = WR_IMM; ex[3] = IDLE; ex[4] = NONE; ex[5] = LDA;
      ex[6] = LDB;  ex[7] = e(0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 0);
      ex[8] = WR_REG; ex[9] = IDLE;
      @(negedge clk);
      bus.s      = 1'b1;
      bus.opcode = OPC_MOV;
      bus.op     = 2'b10;
      @(posedge clk);
      #1;
      bus.opcode = OPC_ALU;
      bus.op     = ALU_ADD;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         got = snap();
         tests_run++;
         if (got !== ex[k]) begin
            tests_failed++;
            $display("FAIL back_to_back cycle %0d: got %h expected %h", k, got, ex[k]);
         end
         if (k == 4) begin
            bus.s      = 1'b0;
            bus.opcode = 3'b000;
            bus.op     = 2'b00;
         end
      end
   endtask

   // Reset asserted while an ADD sits in GET_B
   task automatic test_reset_mid_instr();
      logic [15:0] got;
      logic [2:0]  wwl;
      issue(OPC_ALU, ALU_ADD);
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #2;
      tests_run++;
      if (bus.loadb !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_mid_pre_loadb: got %b expected 1", bus.loadb);
      end
      #1;
      rst_n = 1'b0;
      #1;
      wwl = {bus.w, bus.write, bus.loadb};
      tests_run++;
      if (wwl !== 3'b100) begin
         tests_failed++;
         $display("FAIL rst_mid_async {w,write,loadb}: got %b expected 100", wwl);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         got = snap();
         tests_run++;
         if (got !== IDLE) begin
            tests_failed++;
            $display("FAIL rst_mid_after cycle %0d: got %h expected %h", k, got, IDLE);
         end
      end
   endtask

   task automatic test_illegal();
      logic [15:0] got;
      logic [15:0] halt_v;
      issue(3'b111, 2'b00);
      @(negedge clk);
      got = snap();
      tests_run++;
      if (got !== NONE) begin
         tests_failed++;
         $display("FAIL illegal_decode: got %h expected %h", got, NONE);
      end
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
      halt_v = e(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1);
      for (int k = 0; k < 20; k++) begin
         bus.s      = (k % 2 == 0);
         bus.opcode = OPC_MOV;
         bus.op     = 2'b10;
         @(negedge clk);
         got = snap();
         tests_run++;
         if (got !== halt_v) begin
            tests_failed++;
            $display("FAIL illegal_halt cycle %0d: got %h expected %h", k, got, halt_v);
         end
      end
      bus.s      = 1'b0;
      bus.opcode = 3'b000;
      bus.op     = 2'b00;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      got = snap();
      tests_run++;
      if (got !== IDLE) begin
         tests_failed++;
         $display("FAIL illegal_halt_cleared: got %h expected %h", got, IDLE);
      end
`else
      halt_v = IDLE;
      @(negedge clk);
      got = snap();
      tests_run++;
      if (got !== halt_v) begin
         tests_failed++;
         $display("FAIL illegal_nop: got %h expected %h", got, halt_v);
      end
`endif
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      bus.s        = 1'b0;
      bus.opcode   = 3'b000;
      bus.op       = 2'b00;
      test_reset();
      test_idle_ignores_fields();
      test_mov_imm();
      test_alu3("add", ALU_ADD);
      test_alu3("and", ALU_AND);
      test_cmp();
      test_mov_reg_mvn("mov_reg", OPC_MOV, 2'b00, 1'b1, 2'b00);
      test_mov_reg_mvn("mvn", OPC_ALU, ALU_MVN, 1'b0, 2'b11);
      test_back_to_back();
      test_reset_mid_instr();
      test_illegal();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Multi-cycle controller FSM for the lab simple-RISC datapath; the initiator side of the ALU.
- Latches one instruction on a start pulse and sequences register-file reads, ALU operation, status load and writeback.
- Drives the ALU opcode, pipeline-register loads, mux selects and the register-file write strobe.
- Sits between the instruction decoder (opcode/op fields) and the datapath containing the register file, A/B/C registers, ALU and status register.

Parameters:
- NSEL_W, 3, width of the one-hot register-select (bit0=Rn, bit1=Rd, bit2=Rm)
- VSEL_W, 2, width of the writeback mux select

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- s  in  1  start request, sampled only in WAIT
- opcode  in  3  instruction opcode field
- op  in  2  instruction op field
- w  out  1  idle/ready; 1 only in WAIT
- nsel  out  3  one-hot register select: 001 Rn, 010 Rd, 100 Rm, 000 none
- vsel  out  2  writeback source: 00 C, 01 PC, 10 sximm8, 11 mdata
- loada  out  1  load A register
- loadb  out  1  load B register
- loadc  out  1  load C register
- loads  out  1  load status (Z,N,V) register
- asel  out  1  1 forces ALU A input to 0
- bsel  out  1  1 selects sximm5 for ALU B input (held 0 by this block)
- write  out  1  register-file write enable
- alu_op  out  2  ALU operation: 00 add, 01 sub, 10 and, 11 not-B
- err  out  1  illegal-instruction flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=WAIT; w=1; every other output 0; latched opcode/op cleared to 0. Reset mid-instruction aborts it immediately with no write.
- Outputs are Moore: decoded from the state register and the latched fields only.
- Acceptance: in WAIT with s=1, latch opcode/op and go to DECODE. Inputs are ignored in every other state, and s is ignored while w=0.
- Default outputs in every state are 0, then the per-state overrides below apply:
  - WAIT: w=1.
  - DECODE: no outputs asserted. Next state:
    - {110,10} goes to WRITE_IMM.
    - {110,00} goes to GET_B.
    - {101,11} goes to GET_B.
    - {101,00|01|10} goes to GET_A.
    - Anything else is illegal.
  - GET_A: nsel=001, loada=1; next GET_B.
  - GET_B: nsel=100, loadb=1; next COMPUTE.
  - COMPUTE:
    - Opcode 110: alu_op=00 and asel=1 (shifted Rm passes through).
    - Opcode 101: alu_op=latched op.
    - CMP (op=01): loads=1, loadc=0, next WAIT.
    - Otherwise: loadc=1, next WRITE_REG.
  - WRITE_REG: nsel=010, vsel=00, write=1; next WAIT.
  - WRITE_IMM: nsel=001, vsel=10, write=1; next WAIT.
- Latency from the s-accept edge to w=1:
  - MOV imm: 3 cycles.
  - MOV reg and MVN: 5 cycles.
  - ADD and AND: 6 cycles.
  - CMP: 5 cycles.
- Back-to-back: if s is held high, a new instruction is accepted on the first cycle w=1 is seen.
- write and loads are never asserted in the same cycle. Exactly one of loada/loadb/loadc/loads/write is asserted in any non-WAIT, non-DECODE state.

Optional Feature:
- Macro: DATAPATH_CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal decode goes to HALT. HALT sets err=1 (sticky), w=0, all other outputs 0. The block stays in HALT until rst_n=0.
- Undefined: an illegal decode returns to WAIT next cycle as a NOP; err is tied to 0 and the HALT state is not compiled.

Decomposition:
- Package datapath_ctrl_pkg holds:
  - state enum (WAIT, DECODE, GET_A, GET_B, COMPUTE, WRITE_REG, WRITE_IMM, HALT);
  - opcode constants OPC_MOV=3'b110, OPC_ALU=3'b101;
  - ALU op constants ALU_ADD/SUB/AND/MVN;
  - nsel constants NSEL_RN/RD/RM;
  - vsel constants VSEL_C/PC/IMM/MDATA.
- One sub-module, datapath_ctrl_outdec: a purely combinational state+fields to output decoder. The parent holds the state register and the latched fields.

Test Plan:
- Reset: assert rst_n=0 mid-GET_B of an ADD -> same-edge w=1, write=0, loadb=0; after release, state is WAIT.
- MOV R1,#5 {110,10}: s=1 one cycle -> WRITE_IMM with nsel=001, vsel=10, write=1 exactly one cycle; w=1 three cycles after acceptance.
- ADD {101,00}: ordered one-cycle pulses loada(nsel=001), loadb(nsel=100), loadc(alu_op=00), write(nsel=010, vsel=00); w returns after 6 cycles.
- CMP {101,01}: COMPUTE shows alu_op=01, loads=1, loadc=0; write never asserted; w=1 five cycles after acceptance.
- MOV reg {110,00} and MVN {101,11}: no loada pulse; COMPUTE has asel=1/alu_op=00 and asel=0/alu_op=11 respectively.
- Illegal {111,00}:
  - With DATAPATH_CTRL_ILLEGAL_TRAP_EN: err=1 and w=0 held for 20 cycles while s toggles; cleared only by rst_n.
  - Without the macro: w=1 two cycles after acceptance, with no load or write strobes.
